// File: rtl/csa_stream_accumulator_pkg.sv
// Shared types and helpers for the carry-save stream accumulator.
package csa_stream_accumulator_pkg;

  typedef enum logic [1:0] {
    ST_ACCUM   = 2'd0,
    ST_RESOLVE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  function automatic int acc_width(input int width, input int guard);
    return width + guard;
  endfunction

endpackage

// File: rtl/csa_stream_accumulator_parameterized_csa.sv
// 3:2 carry-save compressor: per-bit sum and majority, no carry propagation.
module parameterized_csa #(
  parameter int WIDTH = 12
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] cin,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] c
);

  assign s = a ^ b ^ cin;
  assign c = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/csa_stream_accumulator.sv
// Streaming multi-operand accumulator: operands fold into a redundant sum/carry
// pair, one carry-propagate add resolves the group total.
//
//   state      | meaning
//   ST_ACCUM   | accepting operands, folding into sum_q/carry_q
//   ST_RESOLVE | one-cycle carry-propagate add into the output registers
//   ST_DONE    | result held until out_ready
module csa_stream_accumulator
  import csa_stream_accumulator_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int GUARD     = 4,
  parameter int CNT_WIDTH = 8,
  parameter int SIGNED    = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH+GUARD-1:0] out_data,
  output logic [CNT_WIDTH-1:0]   out_count,
  output logic                   out_ovf
);

  localparam int ACC_WIDTH = acc_width(WIDTH, GUARD);
  localparam logic [CNT_WIDTH-1:0] OVF_LIMIT = CNT_WIDTH'(2 ** GUARD);

  if (CNT_WIDTH <= GUARD) begin : g_cnt_width_check
    $error("csa_stream_accumulator: CNT_WIDTH must exceed GUARD");
  end

  state_t                 state_q, state_d;
  logic [ACC_WIDTH-1:0]   sum_q, carry_q;
  logic [ACC_WIDTH-1:0]   x_ext, csa_s, csa_c, carry_d;
  logic [CNT_WIDTH-1:0]   cnt_q;
  logic                   accept;

  always_comb begin
    if (SIGNED != 0) x_ext = {{GUARD{in_data[WIDTH-1]}}, in_data};
    else             x_ext = {{GUARD{1'b0}}, in_data};
  end

  parameterized_csa #(.WIDTH(ACC_WIDTH)) u_csa (
    .a   (sum_q),
    .b   (carry_q),
    .cin (x_ext),
    .s   (csa_s),
    .c   (csa_c)
  );

  // Carry weight doubles; the bit shifted out is beyond the modulus.
  assign carry_d  = csa_c << 1;
  assign in_ready = (state_q == ST_ACCUM);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_ACCUM:   if (accept && in_last) state_d = ST_RESOLVE;
      ST_RESOLVE: state_d = ST_DONE;
      ST_DONE:    if (out_ready) state_d = ST_ACCUM;
      default:    state_d = ST_ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_ACCUM;
      sum_q     <= '0;
      carry_q   <= '0;
      cnt_q     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        ST_ACCUM: begin
          if (accept) begin
            sum_q   <= csa_s;
            carry_q <= carry_d;
            cnt_q   <= (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
          end
        end
        ST_RESOLVE: begin
          out_data  <= sum_q + carry_q;
          out_count <= cnt_q;
          out_ovf   <= (cnt_q > OVF_LIMIT);
          out_valid <= 1'b1;
          sum_q     <= '0;
          carry_q   <= '0;
          cnt_q     <= '0;
        end
        ST_DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_csa_stream_accumulator.sv
// Bench: unsigned (index 0) and signed (index 1) accumulators against a
// group-sum reference model, plus directed literal checks.
module tb_csa_stream_accumulator;

  logic        clk;
  logic        rst       [2];
  logic        in_valid  [2];
  logic        in_ready  [2];
  logic [7:0]  in_data   [2];
  logic        in_last   [2];
  logic        out_valid [2];
  logic        out_ready [2];
  logic [11:0] out_data  [2];
  logic [7:0]  out_count [2];
  logic        out_ovf   [2];

  int n_vec = 0;
  int n_err = 0;

  for (genvar k = 0; k < 2; k++) begin : g_dut
    csa_stream_accumulator #(
      .WIDTH(8), .GUARD(4), .CNT_WIDTH(8), .SIGNED(k)
    ) dut (
      .clk       (clk),
      .rst       (rst[k]),
      .in_valid  (in_valid[k]),
      .in_ready  (in_ready[k]),
      .in_data   (in_data[k]),
      .in_last   (in_last[k]),
      .out_valid (out_valid[k]),
      .out_ready (out_ready[k]),
      .out_data  (out_data[k]),
      .out_count (out_count[k]),
      .out_ovf   (out_ovf[k])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: group totals in plain integer arithmetic.
  bit m_acc  [2] = '{1'b1, 1'b1};
  int m_sum  [2] = '{0, 0};
  int m_cnt  [2] = '{0, 0};
  bit m_pend [2] = '{1'b0, 1'b0};
  int m_psum [2] = '{0, 0};
  int m_pcnt [2] = '{0, 0};
  bit m_ov   [2] = '{1'b0, 1'b0};
  int m_od   [2] = '{0, 0};
  int m_oc   [2] = '{0, 0};
  bit m_oo   [2] = '{1'b0, 1'b0};

  function automatic int ext(input int k, input logic [7:0] d);
    if (k == 1 && d[7]) return int'(d) - 256;
    return int'(d);
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst[k]) begin
        m_acc[k] = 1; m_sum[k] = 0; m_cnt[k] = 0; m_pend[k] = 0;
        m_ov[k] = 0; m_od[k] = 0; m_oc[k] = 0; m_oo[k] = 0;
      end else begin
        bit ready_now;
        ready_now = m_acc[k];
        if (m_ov[k] && out_ready[k]) begin
          m_ov[k] = 0;
          m_acc[k] = 1;
        end
        if (m_pend[k]) begin
          m_od[k] = ((m_psum[k] % 4096) + 4096) % 4096;
          m_oc[k] = (m_pcnt[k] > 255) ? 255 : m_pcnt[k];
          m_oo[k] = (m_pcnt[k] > 16);
          m_ov[k] = 1;
          m_pend[k] = 0;
        end
        if (ready_now && in_valid[k]) begin
          m_sum[k] += ext(k, in_data[k]);
          m_cnt[k]++;
          if (in_last[k]) begin
            m_psum[k] = m_sum[k];
            m_pcnt[k] = m_cnt[k];
            m_pend[k] = 1;
            m_sum[k] = 0;
            m_cnt[k] = 0;
            m_acc[k] = 0;
          end
        end
      end
    end
  end

  always @(posedge clk) begin
    #2;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("in_ready[%0d]", k),  32'(in_ready[k]),  32'(m_acc[k]));
      chk($sformatf("out_valid[%0d]", k), 32'(out_valid[k]), 32'(m_ov[k]));
      chk($sformatf("out_data[%0d]", k),  32'(out_data[k]),  32'(m_od[k]));
      chk($sformatf("out_count[%0d]", k), 32'(out_count[k]), 32'(m_oc[k]));
      chk($sformatf("out_ovf[%0d]", k),   32'(out_ovf[k]),   32'(m_oo[k]));
    end
  end

  // Called 1 time unit after an edge; returns 1 time unit after the accepting edge.
  task automatic push(input int k, input logic [7:0] d, input logic last);
    bit done;
    bit ready;
    done = 0;
    in_valid[k] = 1'b1; in_data[k] = d; in_last[k] = last;
    for (int i = 0; i < 50 && !done; i++) begin
      ready = in_ready[k];
      @(posedge clk); #1;
      if (ready) done = 1;
    end
    if (!done) chk("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; in_valid[k] = 1'b0; in_data[k] = '0;
      in_last[k] = 1'b0; out_ready[k] = 1'b1;
    end
    repeat (2) @(posedge clk);
    #1;
    rst[0] = 1'b0; rst[1] = 1'b0;
    chk("t1_in_ready", 32'(in_ready[0]), 32'd1);
    chk("t1_out_valid", 32'(out_valid[0]), 32'd0);
    chk("t1_out_data", 32'(out_data[0]), 32'h000);
    chk("t1_out_count", 32'(out_count[0]), 32'd0);
    step();
    chk("t1_in_ready_next", 32'(in_ready[0]), 32'd1);

    for (int i = 0; i < 3; i++) push(0, 8'hFF, i == 2);
    in_valid[0] = 1'b0; in_last[0] = 1'b0;
    chk("t2_valid_not_early", 32'(out_valid[0]), 32'd0);
    step();
    chk("t2_out_valid", 32'(out_valid[0]), 32'd1);
    chk("t2_out_data", 32'(out_data[0]), 32'h2FD);
    chk("t2_out_count", 32'(out_count[0]), 32'd3);
    chk("t2_out_ovf", 32'(out_ovf[0]), 32'd0);
    step();
    chk("t2_valid_drop", 32'(out_valid[0]), 32'd0);
    chk("t2_in_ready", 32'(in_ready[0]), 32'd1);

    out_ready[0] = 1'b0;
    for (int i = 0; i < 3; i++) push(0, 8'hFF, i == 2);
    in_valid[0] = 1'b0; in_last[0] = 1'b0;
    step();
    chk("t3_out_valid", 32'(out_valid[0]), 32'd1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t3_hold_data", 32'(out_data[0]), 32'h2FD);
      chk("t3_hold_valid", 32'(out_valid[0]), 32'd1);
      chk("t3_hold_in_ready", 32'(in_ready[0]), 32'd0);
    end
    out_ready[0] = 1'b1;
    step();
    chk("t3_valid_drop", 32'(out_valid[0]), 32'd0);
    chk("t3_in_ready", 32'(in_ready[0]), 32'd1);

    for (int i = 0; i < 17; i++) push(0, 8'hFF, i == 16);
    in_valid[0] = 1'b0; in_last[0] = 1'b0;
    step();
    chk("t4_out_data", 32'(out_data[0]), 32'h0EF);
    chk("t4_out_count", 32'(out_count[0]), 32'd17);
    chk("t4_out_ovf", 32'(out_ovf[0]), 32'd1);
    step();

    push(1, 8'h80, 1'b0); push(1, 8'h80, 1'b0); push(1, 8'h01, 1'b1);
    in_valid[1] = 1'b0; in_last[1] = 1'b0;
    step();
    chk("t5_out_data", 32'(out_data[1]), 32'hF01);
    chk("t5_out_count", 32'(out_count[1]), 32'd3);
    chk("t5_out_ovf", 32'(out_ovf[1]), 32'd0);
    step();
    push(1, 8'h5A, 1'b1);
    in_valid[1] = 1'b0; in_last[1] = 1'b0;
    step();
    chk("t5_single_data", 32'(out_data[1]), 32'h05A);
    chk("t5_single_count", 32'(out_count[1]), 32'd1);
    step();

    push(0, 8'h33, 1'b0); push(0, 8'h33, 1'b0);
    in_valid[0] = 1'b0;
    rst[0] = 1'b1;
    step();
    rst[0] = 1'b0;
    chk("t6_in_ready", 32'(in_ready[0]), 32'd1);
    chk("t6_out_valid", 32'(out_valid[0]), 32'd0);
    chk("t6_out_count", 32'(out_count[0]), 32'd0);
    push(0, 8'h01, 1'b1);
    in_valid[0] = 1'b0; in_last[0] = 1'b0;
    chk("t6_no_stale", 32'(out_valid[0]), 32'd0);
    step();
    chk("t6_out_data", 32'(out_data[0]), 32'h001);
    chk("t6_out_count", 32'(out_count[0]), 32'd1);
    chk("t6_out_valid", 32'(out_valid[0]), 32'd1);
    step();

    // Random traffic: short groups first, then long groups to reach overflow.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        rst[k]       = ($urandom_range(0, 149) == 0);
        in_valid[k]  = ($urandom_range(0, 3) != 0);
        in_data[k]   = 8'($urandom);
        in_last[k]   = (c < 2000) ? ($urandom_range(0, 5) == 0)
                                  : ($urandom_range(0, 24) == 0);
        out_ready[k] = ($urandom_range(0, 2) != 0);
      end
    end
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b0; in_valid[k] = 1'b0; out_ready[k] = 1'b1;
    end
    repeat (4) @(posedge clk);
    #3;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
